fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the frame payload width in bits.
REQ-002 SHALL have parameter PRESCALE_W, default 6, the width of the bit-period input.
REQ-003 SHALL have port rclk, input, 1 bit: the single clock (FIFO read domain); all logic rising-edge.
REQ-004 SHALL have port rrst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rempty, input, 1 bit: FIFO read-side empty flag.
REQ-006 SHALL have port rdata, input, DATA_WIDTH bits: FIFO read data, combinational from the current read address.
REQ-007 SHALL have port rinc, output, 1 bit: FIFO read-increment (pop) pulse.
REQ-008 SHALL have port par_en, input, 1 bit: parity-bit enable.
REQ-009 SHALL have port par_typ, input, 1 bit: parity type, 0 = even, 1 = odd.
REQ-010 SHALL have port prescale, input, PRESCALE_W bits: rclk cycles per serial bit.
REQ-011 SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in flight.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL, in IDLE with rempty=0, capture rdata, par_en, par_typ and prescale into internal registers, assert rinc for exactly that one cycle, and enter START.
REQ-015 SHALL never assert rinc while rempty=1 or outside a capture cycle (REQ-014, REQ-022).
REQ-016 SHALL drive tx_out low starting the cycle after the rinc pulse (1-cycle pop-to-start latency).
REQ-017 SHALL hold each serial bit (start, data, parity, stop) for exactly P cycles, where P is the latched prescale, with a latched value of 0 treated as 1.
REQ-018 SHALL use a bit-period counter that counts from 0 to P-1; the state/bit advance occurs on the cycle after the count reaches P-1.
REQ-019 SHALL send data bits LSB first, with a 3-bit index 0..DATA_WIDTH-1 that is reset to 0 on entry to DATA.
REQ-020 SHALL, when the latched par_en=1, send PARITY after DATA with value XOR(byte) for even or ~XOR(byte) for odd; when par_en=0, DATA goes directly to STOP.
REQ-021 SHALL drive STOP high for P cycles.
REQ-022 SHALL, on the last STOP cycle with rempty=0, perform the capture/pop per REQ-014 and enter START directly, giving back-to-back frames with no idle gap.
REQ-023 SHALL, on the last STOP cycle with rempty=1, return to IDLE.
REQ-024 SHALL ignore changes to par_en, par_typ and prescale mid-frame; they affect only the next capture.
REQ-025 SHALL assert busy from the START cycle through the last STOP cycle, and deassert it in IDLE.
REQ-026 SHALL drive tx_out as a registered output (glitch-free) and high in IDLE.

Reset
REQ-027 SHALL, while rrst_n=0, asynchronously force state=IDLE, tx_out=1, rinc=0 and busy=0, and clear all counters and registers.
REQ-028 SHALL abort an in-flight frame if reset asserts mid-frame, with tx_out high immediately; the popped byte is lost and is not re-read.
REQ-029 SHALL not pop during the first rising edge after reset release if rempty was high before that edge.

Verification
REQ-030 SHALL cover single byte 0xA5 with prescale=4 and par_en=0 -> one rinc pulse, then tx_out = 0 followed by 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles, 40 cycles total, with busy high for 40 cycles.
REQ-031 SHALL cover byte 0x07 with par_en=1, par_typ=0, prescale=2 -> parity bit = 1, 22-cycle frame; with par_typ=1 -> parity bit = 0.
REQ-032 SHALL cover three bytes 0x01, 0x80, 0xFF queued with prescale=1 -> 3 rinc pulses spaced 10 cycles apart, 30 contiguous frame cycles, no idle cycle between frames.
REQ-033 SHALL cover prescale changed 8->3 during the DATA state -> current frame keeps 8-cycle bits, next frame uses 3.
REQ-034 SHALL cover rrst_n pulsed low during data bit 3 -> tx_out=1 and busy=0 asynchronously; after release, the next FIFO byte transmits correctly.
REQ-035 SHALL cover rempty held at 1 for 100 cycles -> rinc stays 0, tx_out stays 1, busy stays 0; prescale=0 -> 1-cycle bits.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : UART transmitter fed directly from the read side of a FIFO.
//             Pops one word per frame and serialises it as start bit, data
//             bits (LSB first), optional parity bit and stop bit. Each bit
//             lasts a latched number of clock cycles. Back-to-back frames
//             are sent with no idle gap while the FIFO has data.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_bit_q;
   logic                  par_en_q;
   logic [PRESCALE_W-1:0] period_q;
   logic [PRESCALE_W-1:0] cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  tx_q;
   logic                  busy_q;

   logic [PRESCALE_W-1:0] period_d;
   logic                  bit_last;
   logic                  pop;

   // A prescale of zero would make the bit counter meaningless, so it is
   // promoted to a one-cycle bit when latched.
   assign period_d = (prescale == '0) ? PRESCALE_W'(1) : prescale;

   // Current cycle is the final cycle of the bit being sent.
   assign bit_last = (cnt_q == (period_q - PRESCALE_W'(1)));

   // A word is taken either from idle or on the final stop cycle so that
   // consecutive frames abut. Gated by reset so no pop leaks out while the
   // block is held in reset.
   assign pop = rrst_n & ~rempty &
                ((state_q == IDLE) | ((state_q == STOP) & bit_last));

   assign rinc   = pop;
   assign tx_out = tx_q;
   assign busy   = busy_q;

   // Frame sequencer: captures a word on pop and steps through the bits,
   // driving the serial line from a register.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q   <= IDLE;
         data_q    <= '0;
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
         period_q  <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else if (pop) begin
         // Parity is resolved at capture time so later changes of par_typ
         // cannot affect the frame in flight.
         state_q   <= START;
         data_q    <= rdata;
         par_bit_q <= (^rdata) ^ par_typ;
         par_en_q  <= par_en;
         period_q  <= period_d;
         cnt_q     <= '0;
         idx_q     <= '0;
         tx_q      <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            START: begin
               if (bit_last) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  tx_q    <= data_q[0];
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + PRESCALE_W'(1);
               end
            end
            DATA: begin
               if (bit_last) begin
                  cnt_q <= '0;
                  if (idx_q == C_LAST_IDX) begin
                     if (par_en_q) begin
                        tx_q    <= par_bit_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                     tx_q  <= data_q[idx_q + IDX_W'(1)];
                  end
               end else begin
                  cnt_q <= cnt_q + PRESCALE_W'(1);
               end
            end
            PARITY: begin
               if (bit_last) begin
                  cnt_q   <= '0;
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + PRESCALE_W'(1);
               end
            end
            STOP: begin
               // The pop branch above covers a non-empty FIFO here.
               if (bit_last) begin
                  cnt_q   <= '0;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + PRESCALE_W'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Purpose  : Self-checking bench for fifo_uart_tx. A FIFO model feeds the
//             design; a frame-level reference builds the expected serial
//             waveform cycle by cycle from each popped word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic [5:0] prescale = 6'd4;
   logic       tx_out;
   logic       busy;

   logic [7:0] fifo_q[$];
   logic       exp_q[$];
   logic       frame_bits[$];
   int         pop_cyc[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   logic       m_tx, m_busy, m_rinc;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .rclk     (clk),
      .rrst_n   (rst_n),
      .rempty   (rempty),
      .rdata    (rdata),
      .rinc     (rinc),
      .par_en   (par_en),
      .par_typ  (par_typ),
      .prescale (prescale),
      .tx_out   (tx_out),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic drive_fifo();
      rempty = (fifo_q.size() == 0);
      rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      drive_fifo();
   endtask

   // Expected line levels for one whole frame, one entry per clock cycle.
   task automatic push_frame(input logic [7:0] b, input logic pe, input logic pt,
                             input logic [5:0] ps);
      int   p;
      int   ones;
      logic parity;
      p      = (ps == 0) ? 1 : int'(ps);
      ones   = $countones(b);
      parity = ((ones % 2) == 1) ^ pt;
      for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < p; k++) exp_q.push_back(b[i]);
      if (pe)
         for (int k = 0; k < p; k++) exp_q.push_back(parity);
      for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
   endtask

   // Cycle-level monitor: compares line, busy and pop against the model.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         m_rinc = 1'b0;
         if (!rst_n) begin
            exp_q.delete();
            chk("rst_tx", tx_out, 1);
            chk("rst_busy", busy, 0);
            chk("rst_rinc", rinc, 0);
         end else begin
            m_tx   = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
            m_busy = (exp_q.size() > 0);
            m_rinc = (exp_q.size() <= 1) && (fifo_q.size() > 0);
            chk($sformatf("tx@%0d", cyc), tx_out, m_tx);
            chk($sformatf("busy@%0d", cyc), busy, m_busy);
            chk($sformatf("rinc@%0d", cyc), rinc, m_rinc);
            if (rinc) pop_cyc.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_rinc) push_frame(fifo_q[0], par_en, par_typ, prescale);
         end
         if (m_rinc) begin
            @(posedge clk);
            #1;
            void'(fifo_q.pop_front());
            drive_fifo();
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Waits for busy, then records the line for every busy cycle.
   task automatic frame_len(input int exp_len, input string tag);
      int g;
      int n;
      g = 0;
      n = 0;
      frame_bits.delete();
      @(negedge clk);
      while (!busy && g < 2000) begin @(negedge clk); g++; end
      chk({tag, "_start"}, (g < 2000), 1);
      while (busy && n < 5000) begin
         frame_bits.push_back(tx_out);
         n++;
         @(negedge clk);
      end
      chk({tag, "_len"}, n, exp_len);
      step(1);
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while ((fifo_q.size() != 0 || busy) && g < 5000) begin step(1); g++; end
      chk({tag, "_idle"}, (g < 5000), 1);
      step(2);
   endtask

   int rinc_seen, busy_seen, tx_low;
   logic [7:0] rb;

   initial begin
      drive_fifo();
      step(3);
      chk("reset_tx", tx_out, 1);
      chk("reset_busy", busy, 0);
      chk("reset_rinc", rinc, 0);
      rst_n = 1'b1;
      step(4);

      // 0xA5, prescale 4, no parity
      par_en = 0; prescale = 6'd4;
      push(8'hA5);
      frame_len(40, "a5");
      chk("a5_start_bit", frame_bits[0], 0);
      chk("a5_bit0", frame_bits[4], 1);
      chk("a5_bit1", frame_bits[8], 0);
      chk("a5_bit7", frame_bits[32], 1);
      chk("a5_stop", frame_bits[39], 1);
      wait_idle("a5");

      // 0x07 with even and odd parity, prescale 2
      par_en = 1; par_typ = 0; prescale = 6'd2;
      push(8'h07);
      frame_len(22, "p_even");
      chk("p_even_bit", frame_bits[18], 1);
      wait_idle("p_even");
      par_typ = 1;
      push(8'h07);
      frame_len(22, "p_odd");
      chk("p_odd_bit", frame_bits[18], 0);
      wait_idle("p_odd");

      // Three queued words at prescale 1: contiguous frames
      par_en = 0; prescale = 6'd1;
      pop_cyc.delete();
      push(8'h01); push(8'h80); push(8'hFF);
      frame_len(30, "b2b");
      chk("b2b_pops", pop_cyc.size(), 3);
      if (pop_cyc.size() == 3) begin
         chk("b2b_gap1", pop_cyc[1] - pop_cyc[0], 10);
         chk("b2b_gap2", pop_cyc[2] - pop_cyc[1], 10);
      end
      wait_idle("b2b");

      // Prescale changed mid-frame only affects the next frame
      prescale = 6'd8;
      push(8'h5C); push(8'hC3);
      fork
         frame_len(110, "pschg");
         begin step(30); prescale = 6'd3; end
      join
      wait_idle("pschg");

      // Reset during data bit 3 aborts the frame
      prescale = 6'd4;
      push(8'h35);
      @(negedge clk);
      while (!busy) @(negedge clk);
      repeat (17) @(negedge clk);
      chk("abort_pre_tx", tx_out, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_tx", tx_out, 1);
      chk("abort_busy", busy, 0);
      chk("abort_rinc", rinc, 0);
      step(3);
      rst_n = 1'b1;
      step(2);
      push(8'h5A);
      frame_len(40, "after_rst");
      wait_idle("after_rst");

      // Empty FIFO for 100 cycles: nothing happens
      rinc_seen = 0; busy_seen = 0; tx_low = 0;
      repeat (100) begin
         @(negedge clk);
         if (rinc) rinc_seen++;
         if (busy) busy_seen++;
         if (!tx_out) tx_low++;
      end
      chk("empty_rinc", rinc_seen, 0);
      chk("empty_busy", busy_seen, 0);
      chk("empty_txlow", tx_low, 0);
      step(1);

      // prescale 0 behaves as 1-cycle bits
      prescale = 6'd0;
      push(8'h96);
      frame_len(10, "ps0");
      wait_idle("ps0");

      // Randomised frames with configuration churn
      for (int f = 0; f < 25; f++) begin
         par_en   = 1'($urandom_range(0, 1));
         par_typ  = 1'($urandom_range(0, 1));
         prescale = 6'($urandom_range(0, 5));
         rb = 8'($urandom);
         push(rb);
         if ($urandom_range(0, 2) == 0) push(8'($urandom));
         step($urandom_range(1, 20));
         par_en   = 1'($urandom_range(0, 1));
         par_typ  = 1'($urandom_range(0, 1));
         prescale = 6'($urandom_range(0, 5));
         if ($urandom_range(0, 1) == 1) wait_idle("rand");
      end
      wait_idle("rand_end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
